jb_axi_regs_demux: RTL and testbench

- Parametrised successor to the single-bank top-control wrapper.
- Terminates one AXI4-lite slave port and fans register accesses out to NUM_BANKS register banks over a simple req/ack bus.
- Adds address decode with DECERR, a per-access timeout with SLVERR, and fair read/write arbitration.
- Sits between the AXI interconnect and the jb_*_regs register sets in every top-control block.

---
 rtl/jb_regs_pkg.sv | 20 ++
 rtl/jb_regs_timeout.sv | 43 ++++
 rtl/jb_axi_regs_demux.sv | 257 +++++++++++++++++++++++++
 tb/tb_jb_axi_regs_demux.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jb_regs_pkg.sv
// Shared response codes, FSM state type and sizing helper for the AXI4-lite register demux.
package jb_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BRESP = 2'd2,
        ST_RRESP = 2'd3
    } state_e;

    // Bank-index width; a single bank still gets one index bit so the decode stays uniform.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/jb_regs_timeout.sv
// Loadable down-counter: start arms it, clear disarms it, expire_c flags the last allowed cycle.
module jb_regs_timeout #(
    parameter int unsigned CYCLES = 64
) (
    input  logic clk,
    input  logic arst_n,
    input  logic start,
    input  logic clear,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    // Loaded with CYCLES-1 so zero is reached on the CYCLES-th armed cycle.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            cnt_d    = CNT_W'(CYCLES - 1);
            active_d = 1'b1;
        end else if (clear) begin
            active_d = 1'b0;
        end else if (active_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign expire_c = active_q && (cnt_q == '0);

endmodule

// File: rtl/jb_axi_regs_demux.sv
// AXI4-lite slave fanning single outstanding accesses to NUM_BANKS req/ack register banks.
// Optional JB_REGS_DEMUX_STATS_EN adds saturating DECERR / timeout counters.
module jb_axi_regs_demux
    import jb_regs_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH  = 13,
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned BANK_ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic                                clk,
    input  logic                                arst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]           s_awaddr,
    input  logic                                s_awvalid,
    output logic                                s_awready,
    input  logic [AXI_DATA_WIDTH-1:0]           s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]         s_wstrb,
    input  logic                                s_wvalid,
    output logic                                s_wready,
    output logic [1:0]                          s_bresp,
    output logic                                s_bvalid,
    input  logic                                s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]           s_araddr,
    input  logic                                s_arvalid,
    output logic                                s_arready,
    output logic [AXI_DATA_WIDTH-1:0]           s_rdata,
    output logic [1:0]                          s_rresp,
    output logic                                s_rvalid,
    input  logic                                s_rready,
    output logic [NUM_BANKS-1:0]                reg_req,
    output logic                                reg_wr,
    output logic [BANK_ADDR_WIDTH-1:0]          reg_addr,
    output logic [AXI_DATA_WIDTH-1:0]           reg_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]         reg_wstrb,
    input  logic [NUM_BANKS-1:0]                reg_ack,
    input  logic [NUM_BANKS*AXI_DATA_WIDTH-1:0] reg_rdata,
`ifdef JB_REGS_DEMUX_STATS_EN
    output logic [15:0]                         decerr_cnt,
    output logic [15:0]                         timeout_cnt,
`endif
    input  logic [NUM_BANKS-1:0]                reg_err
);

    localparam int unsigned DW        = AXI_DATA_WIDTH;
    localparam int unsigned SW        = AXI_DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = idx_w(NUM_BANKS);
    localparam int unsigned DEC_SHIFT = BANK_ADDR_WIDTH + IDX_W;

    state_e                     state_q, state_d;
    logic                       prio_q, prio_d;
    logic                       awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                       bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]                 bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DW-1:0]              rdata_q, rdata_d;
    logic [NUM_BANKS-1:0]       reg_req_q, reg_req_d;
    logic                       reg_wr_q, reg_wr_d;
    logic [BANK_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [DW-1:0]              reg_wdata_q, reg_wdata_d;
    logic [SW-1:0]              reg_wstrb_q, reg_wstrb_d;

    logic                       hs_c, dec_err_c, ack_c, err_c, expire_c;
    logic                       wr_cand_c, rd_cand_c, tmo_start_c, tmo_clear_c;
    logic [AXI_ADDR_WIDTH-1:0]  hs_addr_c;
    logic [IDX_W-1:0]           hs_idx_c;
    logic [DW-1:0]              ack_rdata_c;

    // A registered ready is high for the single handshake cycle; decode happens then.
    assign hs_c      = awready_q | arready_q;
    assign hs_addr_c = awready_q ? s_awaddr : s_araddr;
    assign hs_idx_c  = hs_addr_c[BANK_ADDR_WIDTH +: IDX_W];
    assign dec_err_c = ((hs_addr_c >> DEC_SHIFT) != '0) || (32'(hs_idx_c) >= NUM_BANKS);
    assign wr_cand_c = s_awvalid & s_wvalid;
    assign rd_cand_c = s_arvalid;
    assign ack_c     = |(reg_ack & reg_req_q);
    assign err_c     = |(reg_err & reg_req_q);

    always_comb begin
        ack_rdata_c = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (reg_req_q[b]) ack_rdata_c |= reg_rdata[b*DW +: DW];
        end
    end

    jb_regs_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .arst_n   (arst_n),
        .start    (tmo_start_c),
        .clear    (tmo_clear_c),
        .expire_c (expire_c)
    );

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        awready_d   = 1'b0;
        wready_d    = 1'b0;
        arready_d   = 1'b0;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        reg_req_d   = reg_req_q;
        reg_wr_d    = reg_wr_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wstrb_d = reg_wstrb_q;
        tmo_start_c = 1'b0;
        tmo_clear_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs_c) begin
                    if (dec_err_c) begin
                        if (awready_q) begin
                            bvalid_d = 1'b1;
                            bresp_d  = RESP_DECERR;
                            state_d  = ST_BRESP;
                        end else begin
                            rvalid_d = 1'b1;
                            rresp_d  = RESP_DECERR;
                            rdata_d  = '0;
                            state_d  = ST_RRESP;
                        end
                    end else begin
                        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                            reg_req_d[b] = (IDX_W'(b) == hs_idx_c);
                        end
                        reg_wr_d   = awready_q;
                        reg_addr_d = hs_addr_c[BANK_ADDR_WIDTH-1:0];
                        if (awready_q) begin
                            reg_wdata_d = s_wdata;
                            reg_wstrb_d = s_wstrb;
                        end
                        tmo_start_c = 1'b1;
                        state_d     = ST_REQ;
                    end
                end else if (wr_cand_c && (prio_q || !rd_cand_c)) begin
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    if (rd_cand_c) prio_d = 1'b0;
                end else if (rd_cand_c) begin
                    arready_d = 1'b1;
                    if (wr_cand_c) prio_d = 1'b1;
                end
            end
            ST_REQ: begin
                // An ack in the expiry cycle wins over the timeout.
                if (ack_c || expire_c) begin
                    reg_req_d   = '0;
                    tmo_clear_c = 1'b1;
                    if (reg_wr_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = (ack_c && !err_c) ? RESP_OKAY : RESP_SLVERR;
                        state_d  = ST_BRESP;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = (ack_c && !err_c) ? RESP_OKAY : RESP_SLVERR;
                        rdata_d  = ack_c ? ack_rdata_c : '0;
                        state_d  = ST_RRESP;
                    end
                end
            end
            ST_BRESP: begin
                if (s_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RRESP: begin
                if (s_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            rvalid_q    <= 1'b0;
            rresp_q     <= '0;
            rdata_q     <= '0;
            reg_req_q   <= '0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            arready_q   <= arready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            reg_req_q   <= reg_req_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wstrb_q <= reg_wstrb_d;
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_arready = arready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign reg_req   = reg_req_q;
    assign reg_wr    = reg_wr_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wstrb = reg_wstrb_q;

`ifdef JB_REGS_DEMUX_STATS_EN
    logic [15:0] decerr_cnt_q, decerr_cnt_d, timeout_cnt_q, timeout_cnt_d;

    // Saturating event counters for decode errors and expired accesses.
    always_comb begin
        decerr_cnt_d  = decerr_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        if ((state_q == ST_IDLE) && hs_c && dec_err_c && (decerr_cnt_q != 16'hFFFF))
            decerr_cnt_d = decerr_cnt_q + 16'd1;
        if ((state_q == ST_REQ) && !ack_c && expire_c && (timeout_cnt_q != 16'hFFFF))
            timeout_cnt_d = timeout_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            decerr_cnt_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            decerr_cnt_q  <= decerr_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign decerr_cnt  = decerr_cnt_q;
    assign timeout_cnt = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_jb_axi_regs_demux.sv
// Directed self-checking bench for jb_axi_regs_demux (3 banks, 64-cycle timeout).
module tb_jb_axi_regs_demux;

    localparam int unsigned AW  = 13;
    localparam int unsigned DW  = 32;
    localparam int unsigned NB  = 3;
    localparam int unsigned BAW = 8;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [AW-1:0]   s_awaddr, s_araddr;
    logic            s_awvalid, s_awready, s_wvalid, s_wready, s_arvalid, s_arready;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [3:0]      s_wstrb;
    logic [1:0]      s_bresp, s_rresp;
    logic            s_bvalid, s_bready, s_rvalid, s_rready;
    logic [NB-1:0]   reg_req;
    logic            reg_wr;
    logic [BAW-1:0]  reg_addr;
    logic [DW-1:0]   reg_wdata;
    logic [3:0]      reg_wstrb;
    logic [NB-1:0]   reg_ack = '0;
    logic [NB*DW-1:0] reg_rdata;
    logic [NB-1:0]   reg_err;
`ifdef JB_REGS_DEMUX_STATS_EN
    logic [15:0]     decerr_cnt, timeout_cnt;
`endif

    int unsigned     ack_dly = 0;
    int unsigned     wait_cnt = 0;
    logic [NB-1:0]   bank_err = '0;
    bit              wrong_ack = 1'b0;
    int              n_vec = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    jb_axi_regs_demux #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .NUM_BANKS(NB),
        .BANK_ADDR_WIDTH(BAW), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata),
`ifdef JB_REGS_DEMUX_STATS_EN
        .decerr_cnt(decerr_cnt), .timeout_cnt(timeout_cnt),
`endif
        .reg_err(reg_err)
    );

    // Bank model: fixed read data per bank, ack the requested bank ack_dly cycles after req.
    assign reg_rdata = {32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_BEEF};
    assign reg_err   = bank_err;

    always @(posedge clk) begin
        #2;
        reg_ack = '0;
        if (reg_req != '0) begin
            if (wait_cnt == ack_dly) begin
                reg_ack  = reg_req;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
            if (wrong_ack) reg_ack = reg_ack | ~reg_req;
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the AW/W handshake edge, i.e. when reg_req should be up.
    task automatic send_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] st);
        bit seen = 1'b0;
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = s_awready;
        end
        check("awready_seen", 64'(seen), 64'd1);
        check("wready_with_aw", 64'(s_wready), 64'd1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic send_rd(input logic [AW-1:0] a);
        bit seen = 1'b0;
        s_araddr = a; s_arvalid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = s_arready;
        end
        check("arready_seen", 64'(seen), 64'd1);
        tick();
        s_arvalid = 1'b0;
    endtask

    task automatic wait_rsp(input bit is_wr, output int cyc);
        cyc = 0;
        while (cyc < 300 && !(is_wr ? s_bvalid : s_rvalid)) begin
            tick();
            cyc++;
        end
        check(is_wr ? "bvalid_seen" : "rvalid_seen", 64'(is_wr ? s_bvalid : s_rvalid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n_r, n_w, n;
        logic [3:0] ord;
        bit drop_ar;
        arst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_bready = 1'b1; s_rready = 1'b1;
        repeat (3) tick();
        check("rst_axi", 64'({s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp, s_rdata}), 64'd0);
        check("rst_reg", 64'({reg_req, reg_wr, reg_addr, reg_wdata, reg_wstrb}), 64'd0);
        arst_n = 1'b1;
        tick();

        // Write to bank 1, ack three cycles after req.
        ack_dly = 3; bank_err = 3'b000;
        send_wr(13'h104, 32'hDEAD_BEEF, 4'hF);
        check("w1_req", 64'(reg_req), 64'(3'b010));
        check("w1_addr", 64'(reg_addr), 64'h04);
        check("w1_wr", 64'(reg_wr), 64'd1);
        check("w1_wdata", 64'(reg_wdata), 64'hDEAD_BEEF);
        check("w1_wstrb", 64'(reg_wstrb), 64'hF);
        wait_rsp(1'b1, cyc);
        check("w1_lat", 64'(cyc), 64'd4);
        check("w1_bresp", 64'(s_bresp), 64'(2'b00));
        check("w1_req_drop", 64'(reg_req), 64'd0);
        tick();

        // Same write, bank reports error.
        bank_err = 3'b010;
        send_wr(13'h104, 32'hDEAD_BEEF, 4'hF);
        wait_rsp(1'b1, cyc);
        check("w2_bresp", 64'(s_bresp), 64'(2'b10));
        tick();

        // Read bank 2 with same-cycle ack: rvalid two cycles after the handshake cycle.
        ack_dly = 0; bank_err = 3'b000;
        send_rd(13'h208);
        check("r1_req", 64'(reg_req), 64'(3'b100));
        check("r1_addr", 64'(reg_addr), 64'h08);
        check("r1_wr", 64'(reg_wr), 64'd0);
        check("r1_rvalid_t1", 64'(s_rvalid), 64'd0);
        tick();
        check("r1_rvalid_t2", 64'(s_rvalid), 64'd1);
        check("r1_rdata", 64'(s_rdata), 64'h1234_5678);
        check("r1_rresp", 64'(s_rresp), 64'(2'b00));
        check("r1_req_drop", 64'(reg_req), 64'd0);
        tick();

        // Acks (with errors) from unselected banks must be ignored.
        ack_dly = 2; wrong_ack = 1'b1; bank_err = 3'b101;
        send_rd(13'h104);
        wait_rsp(1'b0, cyc);
        check("wrong_ack_lat", 64'(cyc), 64'd3);
        check("wrong_ack_rdata", 64'(s_rdata), 64'hCAFE_F00D);
        check("wrong_ack_rresp", 64'(s_rresp), 64'(2'b00));
        tick();
        wrong_ack = 1'b0; bank_err = 3'b000;

        // Bank index 3 does not exist with three banks.
        send_rd(13'h300);
        check("dec_r_req", 64'(reg_req), 64'd0);
        check("dec_r_rvalid", 64'(s_rvalid), 64'd1);
        check("dec_r_rresp", 64'(s_rresp), 64'(2'b11));
        check("dec_r_rdata", 64'(s_rdata), 64'd0);
`ifdef JB_REGS_DEMUX_STATS_EN
        check("decerr_cnt_1", 64'(decerr_cnt), 64'd1);
`endif
        tick();

        // Address bit above the index field.
        send_wr(13'h500, 32'h0000_0001, 4'h1);
        check("dec_w_req", 64'(reg_req), 64'd0);
        check("dec_w_bvalid", 64'(s_bvalid), 64'd1);
        check("dec_w_bresp", 64'(s_bresp), 64'(2'b11));
        check("dec_w_wdata_kept", 64'(reg_wdata), 64'hDEAD_BEEF);
`ifdef JB_REGS_DEMUX_STATS_EN
        check("decerr_cnt_2", 64'(decerr_cnt), 64'd2);
`endif
        tick();

        // Ack in the 64th req cycle beats the timeout.
        ack_dly = 63;
        send_rd(13'h208);
        n = 0;
        for (int i = 0; i < 300 && !s_rvalid; i++) begin
            if (reg_req != '0) n++;
            tick();
        end
        check("ack64_req_cycles", 64'(n), 64'd64);
        check("ack64_rvalid", 64'(s_rvalid), 64'd1);
        check("ack64_rresp", 64'(s_rresp), 64'(2'b00));
        check("ack64_rdata", 64'(s_rdata), 64'h1234_5678);
        tick();

        // No ack at all: SLVERR after 64 req cycles.
        ack_dly = 1000;
        send_rd(13'h208);
        n = 0;
        for (int i = 0; i < 300 && !s_rvalid; i++) begin
            if (reg_req != '0) n++;
            tick();
        end
        check("tmo_req_cycles", 64'(n), 64'd64);
        check("tmo_rvalid", 64'(s_rvalid), 64'd1);
        check("tmo_rresp", 64'(s_rresp), 64'(2'b10));
        check("tmo_rdata", 64'(s_rdata), 64'd0);
`ifdef JB_REGS_DEMUX_STATS_EN
        check("timeout_cnt_1", 64'(timeout_cnt), 64'd1);
`endif
        tick();

        // Read and write offered together: alternate starting with read.
        ack_dly = 0;
        s_araddr = 13'h208; s_arvalid = 1'b1;
        s_awaddr = 13'h104; s_wdata = 32'h0F0F_0F0F; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        n_r = 0; n_w = 0; ord = '0; drop_ar = 1'b0;
        for (int i = 0; i < 400 && (n_r + n_w) < 4; i++) begin
            tick();
            if (drop_ar) begin
                s_arvalid = 1'b0;
                drop_ar = 1'b0;
            end
            if (s_arready) begin
                ord = {ord[2:0], 1'b0};
                n_r++;
                if (n_r == 2) drop_ar = 1'b1;
            end
            if (s_awready) begin
                ord = {ord[2:0], 1'b1};
                n_w++;
            end
        end
        tick();
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("arb_count", 64'(n_r + n_w), 64'd4);
        check("arb_order", 64'(ord), 64'(4'b0101));
        wait_rsp(1'b1, cyc);
        check("arb_bresp", 64'(s_bresp), 64'(2'b00));
        tick();

        // Response held while bready is low.
        s_bready = 1'b0; ack_dly = 1; bank_err = 3'b010;
        send_wr(13'h108, 32'h55AA_55AA, 4'h3);
        check("hold_addr", 64'(reg_addr), 64'h08);
        check("hold_wstrb", 64'(reg_wstrb), 64'h3);
        wait_rsp(1'b1, cyc);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_bvalid", 64'(s_bvalid), 64'd1);
            check("hold_bresp", 64'(s_bresp), 64'(2'b10));
        end
        s_bready = 1'b1;
        tick();
        check("hold_release", 64'(s_bvalid), 64'd0);
        bank_err = 3'b000;

        // Asynchronous reset in the middle of a request.
        ack_dly = 1000;
        send_rd(13'h208);
        check("rst_mid_req", 64'(reg_req), 64'(3'b100));
        tick();
        tick();
        #2;
        arst_n = 1'b0;
        #1;
        check("rst_mid_axi", 64'({s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp, s_rdata}), 64'd0);
        check("rst_mid_reg", 64'({reg_req, reg_wr, reg_addr, reg_wdata, reg_wstrb}), 64'd0);
        tick();
        tick();
        arst_n = 1'b1;
`ifdef JB_REGS_DEMUX_STATS_EN
        check("rst_decerr_cnt", 64'(decerr_cnt), 64'd0);
        check("rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
`endif
        ack_dly = 0;
        send_rd(13'h104);
        check("post_rst_req", 64'(reg_req), 64'(3'b010));
        tick();
        check("post_rst_rvalid", 64'(s_rvalid), 64'd1);
        check("post_rst_rdata", 64'(s_rdata), 64'hCAFE_F00D);
        check("post_rst_rresp", 64'(s_rresp), 64'(2'b00));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
